// File: rtl/clint_timer.sv
// Core-local interruptor: 64-bit machine timer, timer compare and software-interrupt register behind a
// request/response register port. Optional mtime prescaler is enabled with `define CLINT_PRESCALER_EN.
module clint_timer #(
  parameter int unsigned PRESCALE = 1
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [15:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_wstrb,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_error,
  output logic        timer_int,
  output logic        soft_int
);

  typedef enum logic {IDLE, RESP} state_t;

  localparam logic [15:0] ADDR_MSIP     = 16'h0000;
  localparam logic [15:0] ADDR_CMP_LO   = 16'h4000;
  localparam logic [15:0] ADDR_CMP_HI   = 16'h4004;
  localparam logic [15:0] ADDR_MTIME_LO = 16'hBFF8;
  localparam logic [15:0] ADDR_MTIME_HI = 16'hBFFC;

  if (PRESCALE == 0 || PRESCALE > 65535) begin : g_bad_prescale
    $error("clint_timer: PRESCALE must be in 1..65535");
  end

  state_t      state;
  logic [63:0] mtime;
  logic [63:0] mtimecmp;
  logic        msip;
  logic        tick;
  logic [31:0] read_data;

  logic sel_msip, sel_cmp_lo, sel_cmp_hi, sel_time_lo, sel_time_hi, addr_ok;
  logic accept, do_write, wr_time_lo, wr_time_hi;

  // Exact-match decode on word addresses also rejects misaligned offsets.
  assign sel_msip    = (req_addr == ADDR_MSIP);
  assign sel_cmp_lo  = (req_addr == ADDR_CMP_LO);
  assign sel_cmp_hi  = (req_addr == ADDR_CMP_HI);
  assign sel_time_lo = (req_addr == ADDR_MTIME_LO);
  assign sel_time_hi = (req_addr == ADDR_MTIME_HI);
  assign addr_ok     = sel_msip | sel_cmp_lo | sel_cmp_hi | sel_time_lo | sel_time_hi;

  assign accept     = (state == IDLE) && req_valid;
  assign do_write   = accept && req_write && addr_ok;
  // An all-zero strobe is a no-op and must not steal the tick.
  assign wr_time_lo = do_write && sel_time_lo && (req_wstrb != 4'b0000);
  assign wr_time_hi = do_write && sel_time_hi && (req_wstrb != 4'b0000);

  assign soft_int = msip;

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                              input logic [31:0] new_val,
                                              input logic [3:0]  strb);
    logic [31:0] res;
    res = old_val;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) res[8*b +: 8] = new_val[8*b +: 8];
    end
    return res;
  endfunction

`ifdef CLINT_PRESCALER_EN
  localparam logic [15:0] PRE_LAST = 16'(PRESCALE - 1);
  logic [15:0] pre_cnt;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) pre_cnt <= '0;
    else          pre_cnt <= (pre_cnt == PRE_LAST) ? 16'd0 : pre_cnt + 16'd1;
  end

  assign tick = (pre_cnt == PRE_LAST);
`else
  assign tick = 1'b1;
`endif

  // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
  always_comb begin
    read_data = '0;
    if      (sel_msip)    read_data = {31'b0, msip};
    else if (sel_cmp_lo)  read_data = mtimecmp[31:0];
    else if (sel_cmp_hi)  read_data = mtimecmp[63:32];
    else if (sel_time_lo) read_data = mtime[31:0];
    else if (sel_time_hi) read_data = mtime[63:32];
  end

  // NOTE: sequential state uses non-blocking assignments so all flops sample pre-edge values.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      mtime     <= '0;
      mtimecmp  <= '1;
      msip      <= 1'b0;
      timer_int <= 1'b0;
    end else begin
      timer_int <= (mtime >= mtimecmp);
      if (wr_time_lo || wr_time_hi) begin
        // Write beats tick: the untouched half keeps its pre-tick value, no carry.
        if (wr_time_lo) mtime[31:0]  <= merge_bytes(mtime[31:0], req_wdata, req_wstrb);
        if (wr_time_hi) mtime[63:32] <= merge_bytes(mtime[63:32], req_wdata, req_wstrb);
      end else if (tick) begin
        mtime <= mtime + 64'd1;
      end
      if (do_write && sel_cmp_lo)
        mtimecmp[31:0] <= merge_bytes(mtimecmp[31:0], req_wdata, req_wstrb);
      if (do_write && sel_cmp_hi)
        mtimecmp[63:32] <= merge_bytes(mtimecmp[63:32], req_wdata, req_wstrb);
      if (do_write && sel_msip && req_wstrb[0])
        msip <= req_wdata[0];
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_error <= 1'b0;
    end else begin
      unique case (state)
        IDLE: if (req_valid) begin
          state      <= RESP;
          req_ready  <= 1'b0;
          resp_valid <= 1'b1;
          resp_rdata <= (addr_ok && !req_write) ? read_data : 32'd0;
          resp_error <= !addr_ok;
        end
        RESP: if (resp_ready) begin
          state      <= IDLE;
          req_ready  <= 1'b1;
          resp_valid <= 1'b0;
          resp_rdata <= '0;
          resp_error <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_clint_timer.sv
// Randomized bench for clint_timer against a register-level reference model of the CLINT.
// Define CLINT_PRESCALER_EN for both files to exercise PRESCALE = 4.
module tb_clint_timer;

`ifdef CLINT_PRESCALER_EN
  localparam int PRE = 4;
`else
  localparam int PRE = 1;
`endif

  logic        clock = 1'b0;
  logic        reset_n;
  logic        req_valid, req_ready, req_write;
  logic [15:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_wstrb;
  logic        resp_valid, resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_error, timer_int, soft_int;

  clint_timer #(.PRESCALE(PRE)) dut (
    .clock(clock), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
    .resp_error(resp_error), .timer_int(timer_int), .soft_int(soft_int)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // Reference model: architectural registers plus the outstanding response.
  logic [63:0] m_mtime, m_cmp;
  logic        m_msip, m_tint, m_busy, m_err;
  logic [31:0] m_rdata;
  int          cyc;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  task automatic model_reset();
    m_mtime = 64'd0;  m_cmp = '1;  m_msip = 1'b0;  m_tint = 1'b0;
    m_busy = 1'b0;    m_err = 1'b0; m_rdata = 32'd0; cyc = 0;
  endtask

  function automatic logic [31:0] mrg(input logic [31:0] o, input logic [31:0] n, input logic [3:0] s);
    logic [31:0] r;
    r = o;
    for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = n[8*b +: 8];
    return r;
  endfunction

  function automatic bit is_mapped(input logic [15:0] a);
    return a == 16'h0000 || a == 16'h4000 || a == 16'h4004 || a == 16'hBFF8 || a == 16'hBFFC;
  endfunction

  function automatic logic [31:0] reg_read(input logic [15:0] a);
    case (a)
      16'h0000: return {31'b0, m_msip};
      16'h4000: return m_cmp[31:0];
      16'h4004: return m_cmp[63:32];
      16'hBFF8: return m_mtime[31:0];
      16'hBFFC: return m_mtime[63:32];
      default:  return 32'd0;
    endcase
  endfunction

  task automatic check_outputs();
    check("req_ready",  {63'b0, req_ready},  {63'b0, !m_busy});
    check("resp_valid", {63'b0, resp_valid}, {63'b0, m_busy});
    if (m_busy) begin
      check("resp_rdata", {32'b0, resp_rdata}, {32'b0, m_rdata});
      check("resp_error", {63'b0, resp_error}, {63'b0, m_err});
    end
    check("timer_int", {63'b0, timer_int}, {63'b0, m_tint});
    check("soft_int",  {63'b0, soft_int},  {63'b0, m_msip});
  endtask

  // Advance one clock: predict the edge from current inputs, then compare after it.
  task automatic step();
    logic [63:0] n_mtime, n_cmp;
    logic        n_msip, n_tint, n_busy, n_err;
    logic [31:0] n_rdata, tmp;
    bit          tick, wrote_time;
    tick = ((cyc % PRE) == PRE - 1);
    n_tint = (m_mtime >= m_cmp);
    n_cmp = m_cmp; n_msip = m_msip; n_busy = m_busy; n_err = m_err; n_rdata = m_rdata;
    wrote_time = 1'b0;
    n_mtime = m_mtime;
    if (!m_busy && req_valid) begin
      n_busy  = 1'b1;
      n_err   = !is_mapped(req_addr);
      n_rdata = (!n_err && !req_write) ? reg_read(req_addr) : 32'd0;
      if (!n_err && req_write && req_wstrb != 4'b0000) begin
        case (req_addr)
          16'h0000: begin tmp = mrg({31'b0, m_msip}, req_wdata, req_wstrb); n_msip = tmp[0]; end
          16'h4000: n_cmp[31:0]  = mrg(m_cmp[31:0], req_wdata, req_wstrb);
          16'h4004: n_cmp[63:32] = mrg(m_cmp[63:32], req_wdata, req_wstrb);
          16'hBFF8: begin n_mtime[31:0]  = mrg(m_mtime[31:0], req_wdata, req_wstrb);  wrote_time = 1'b1; end
          16'hBFFC: begin n_mtime[63:32] = mrg(m_mtime[63:32], req_wdata, req_wstrb); wrote_time = 1'b1; end
          default: ;
        endcase
      end
    end else if (m_busy && resp_ready) begin
      n_busy = 1'b0;
    end
    if (!wrote_time && tick) n_mtime = m_mtime + 64'd1;
    @(posedge clock);
    #1;
    cyc++;
    m_mtime = n_mtime; m_cmp = n_cmp; m_msip = n_msip; m_tint = n_tint;
    m_busy = n_busy; m_err = n_err; m_rdata = n_rdata;
    check_outputs();
  endtask

  task automatic idle(input int n);
    req_valid = 1'b0;
    repeat (n) step();
  endtask

  task automatic txn(input bit wr, input logic [15:0] a, input logic [31:0] d,
                     input logic [3:0] s, input int hold);
    req_valid = 1'b1; req_write = wr; req_addr = a; req_wdata = d; req_wstrb = s; resp_ready = 1'b0;
    step();
    for (int i = 0; i < hold; i++) begin
      // Bus noise during RESP must be ignored.
      req_valid = 1'($urandom); req_write = 1'($urandom); req_addr = 16'($urandom);
      req_wdata = $urandom; req_wstrb = 4'($urandom);
      step();
    end
    resp_ready = 1'b1;
    step();
    resp_ready = 1'b0; req_valid = 1'b0; req_write = 1'b0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    req_valid = 1'b0; resp_ready = 1'b0;
    #2;
    model_reset();
    check("rst_req_ready",  {63'b0, req_ready},  64'd1);
    check("rst_resp_valid", {63'b0, resp_valid}, 64'd0);
    check("rst_resp_rdata", {32'b0, resp_rdata}, 64'd0);
    check("rst_resp_error", {63'b0, resp_error}, 64'd0);
    check("rst_timer_int",  {63'b0, timer_int},  64'd0);
    check("rst_soft_int",   {63'b0, soft_int},   64'd0);
    @(posedge clock);
    #1;
    reset_n = 1'b1;
  endtask

  logic [15:0] addr_tbl [8];

  initial begin
    addr_tbl[0] = 16'h0000; addr_tbl[1] = 16'h4000; addr_tbl[2] = 16'h4004; addr_tbl[3] = 16'hBFF8;
    addr_tbl[4] = 16'hBFFC; addr_tbl[5] = 16'h1234; addr_tbl[6] = 16'h4002; addr_tbl[7] = 16'h0004;
    req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0; req_wstrb = '0;
    resp_ready = 1'b0;
    reset_n = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    do_reset();

    // Idle count, then software interrupt set/read/clear.
    idle(10);
    txn(1'b0, 16'hBFF8, 32'd0, 4'h0, 0);
    txn(1'b1, 16'h0000, 32'h1, 4'hF, 0);
    txn(1'b0, 16'h0000, 32'd0, 4'h0, 1);
    txn(1'b1, 16'h0000, 32'h0, 4'hF, 0);

    // Async reset while a response is pending.
    req_valid = 1'b1; req_write = 1'b0; req_addr = 16'h4000; resp_ready = 1'b0;
    step();
    req_valid = 1'b0;
    step(); step();
    #3;
    do_reset();

    // Compare at 20, observe rise, then push compare away.
    txn(1'b1, 16'h4004, 32'd0, 4'hF, 0);
    txn(1'b1, 16'h4000, 32'd20, 4'hF, 0);
    idle(25 * PRE);
    txn(1'b1, 16'h4000, 32'hFFFF_FFFF, 4'hF, 0);
    idle(3);

    // Wrap-around of the 64-bit counter.
    txn(1'b1, 16'hBFFC, 32'hFFFF_FFFF, 4'hF, 0);
    txn(1'b1, 16'hBFF8, 32'hFFFF_FFFE, 4'hF, 0);
    idle(2 * PRE);
    txn(1'b0, 16'hBFF8, 32'd0, 4'h0, 0);
    txn(1'b0, 16'hBFFC, 32'd0, 4'h0, 0);

    // Error accesses, then back-pressure with a held read.
    txn(1'b0, 16'h1234, 32'd0, 4'h0, 0);
    txn(1'b1, 16'h4002, 32'hDEAD_BEEF, 4'hF, 0);
    txn(1'b0, 16'h4000, 32'd0, 4'h0, 0);
    txn(1'b1, 16'h4000, 32'h1234_5678, 4'h0, 0);
    txn(1'b0, 16'hBFF8, 32'd0, 4'h0, 5);

    for (int n = 0; n < 200; n++) begin
      logic [15:0] a;
      logic [31:0] d;
      logic [3:0]  s;
      int          k;
      k = $urandom_range(0, 9);
      a = (k < 8) ? addr_tbl[k] : 16'($urandom);
      d = $urandom;
      if ((a == 16'h4000 || a == 16'hBFF8) && $urandom_range(0, 1) == 1)
        d = m_mtime[31:0] + 32'($urandom_range(0, 12));
      if ((a == 16'h4004 || a == 16'hBFFC) && $urandom_range(0, 1) == 1)
        d = m_mtime[63:32];
      s = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'hF;
      txn(1'($urandom), a, d, s, $urandom_range(0, 3));
      idle($urandom_range(0, 3));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
